// File: rtl/dual_ram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM, with bounded bursts and fair tie-breaking.
// Optional per-requester transfer counters are enabled by defining ARB_STATS_EN.
module dual_ram_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [7:0]  adr_a,
    input  logic [7:0]  adr_b,
    input  logic [7:0]  din_a,
    input  logic [7:0]  din_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [7:0]  rdata_a,
    output logic [7:0]  rdata_b,
    output logic        rvalid_a,
    output logic        rvalid_b,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [7:0]  ram_adr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] xfer_cnt_a,
    output logic [15:0] xfer_cnt_b
`endif
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state_reg, state_next;
    logic [3:0] burst_reg, burst_next;
    logic       last_b_reg, last_b_next;   // 1 = B was served most recently

    logic [1:0] xfer;
    logic [1:0] rd_issue;
    logic [1:0] rvalid_reg;
    logic [7:0] hold_reg [2];
    logic [7:0] rdata_w  [2];

    assign gnt_a = (state_reg == OWN_A);
    assign gnt_b = (state_reg == OWN_B);

    assign xfer[0]     = gnt_a & req_a;
    assign xfer[1]     = gnt_b & req_b;
    assign rd_issue[0] = xfer[0] & ~we_a;
    assign rd_issue[1] = xfer[1] & ~we_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            burst_reg  <= 4'd0;
            last_b_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            burst_reg  <= burst_next;
            last_b_reg <= last_b_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        burst_next  = burst_reg;
        last_b_next = last_b_reg;
        ram_ce      = 1'b0;
        ram_we      = 1'b0;
        ram_adr     = 8'd0;
        ram_din     = 8'd0;
        case (state_reg)
            IDLE: begin
                // On a tie, the requester not served last wins.
                if (req_a && (!req_b || last_b_reg))
                    state_next = OWN_A;
                else if (req_b)
                    state_next = OWN_B;
            end
            OWN_A: begin
                if (!req_a) begin
                    state_next = req_b ? OWN_B : IDLE;
                    burst_next = 4'd0;
                end else begin
                    ram_ce      = 1'b1;
                    ram_we      = we_a;
                    ram_adr     = adr_a;
                    ram_din     = din_a;
                    last_b_next = 1'b0;
                    if (burst_reg == BURST_LAST) begin
                        burst_next = 4'd0;
                        if (req_b)
                            state_next = OWN_B;
                    end else begin
                        burst_next = burst_reg + 4'd1;
                    end
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_next = req_a ? OWN_A : IDLE;
                    burst_next = 4'd0;
                end else begin
                    ram_ce      = 1'b1;
                    ram_we      = we_b;
                    ram_adr     = adr_b;
                    ram_din     = din_b;
                    last_b_next = 1'b1;
                    if (burst_reg == BURST_LAST) begin
                        burst_next = 4'd0;
                        if (req_a)
                            state_next = OWN_A;
                    end else begin
                        burst_next = burst_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                burst_next = 4'd0;
            end
        endcase
    end

    // Read return path per requester: tagged at issue, so it survives a handover.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg[gi] <= 1'b0;
                    hold_reg[gi]   <= 8'd0;
                end else begin
                    rvalid_reg[gi] <= rd_issue[gi];
                    if (rvalid_reg[gi])
                        hold_reg[gi] <= ram_dout;
                end
            end
            assign rdata_w[gi] = rvalid_reg[gi] ? ram_dout : hold_reg[gi];
        end
    endgenerate

    assign rvalid_a = rvalid_reg[0];
    assign rvalid_b = rvalid_reg[1];
    assign rdata_a  = rdata_w[0];
    assign rdata_b  = rdata_w[1];

`ifdef ARB_STATS_EN
    logic [15:0] cnt_reg [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg[gi] <= 16'd0;
                else if (xfer[gi] && cnt_reg[gi] != 16'hFFFF)
                    cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
        end
    endgenerate

    assign xfer_cnt_a = cnt_reg[0];
    assign xfer_cnt_b = cnt_reg[1];
`endif

endmodule
